// File: rtl/cnt_pkg.sv
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared helpers and constants for the prescaled counter family.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

    // Direction encoding on the up/down select.
    localparam logic CNT_DIR_UP = 1'b1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_prescaler.sv
// ============================================================================
//  Module      : clk_prescaler
//  Description : Enable-gated divide-by-PRESCALE producing a one-cycle step.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int                c_PS_W   = cnt_width(PRESCALE);
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "clk_prescaler: PRESCALE must be >= 1");
    end

    logic [c_PS_W-1:0] r_ps;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ps <= '0;
        end else if (en) begin
            r_ps <= (r_ps == c_PS_MAX) ? '0 : r_ps + 1'b1;
        end
    end

    assign step = en && (r_ps == c_PS_MAX);

endmodule

`default_nettype wire

// File: rtl/prescaled_counter.sv
// ============================================================================
//  Module      : prescaled_counter
//  Description : Modulo counter advanced by an internal prescaler step, with
//                clamped synchronous load. Define CNT_UPDOWN_EN for up/down.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prescaled_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 100,
    parameter int MODULO   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CNT_UPDOWN_EN
    input  logic             up,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH + 1)'(MODULO);

    if (PRESCALE < 1 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_params
        $fatal(1, "prescaled_counter: illegal PRESCALE/MODULO for WIDTH");
    end

    logic             w_step;
    logic             w_up;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_tc;

`ifdef CNT_UPDOWN_EN
    assign w_up = up;
`else
    assign w_up = CNT_DIR_UP;
`endif

    // Load restarts the prescale interval so the next step is a full period away.
    clk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (w_step)
    );

    assign w_load_sat = ({1'b0, load_val} >= c_MOD_EXT) ? c_MAX : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_sat;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_tick <= 1'b1;
            if (w_up == CNT_DIR_UP) begin
                r_tc    <= (r_count == c_MAX);
                r_count <= (r_count == c_MAX) ? '0 : r_count + 1'b1;
            end else begin
                r_tc    <= (r_count == '0);
                r_count <= (r_count == '0) ? c_MAX : r_count - 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign tc    = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_prescaled_counter.sv
// ============================================================================
//  Module      : tb_prescaled_counter
//  Description : Self-checking bench for prescaled_counter (W=4, P=4, M=10).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prescaled_counter;

    localparam int W = 4;
    localparam int P = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst, en, load, up;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tick, tc;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference state
    int   m_ps, m_count;
    logic m_tick, m_tc;
    logic [W+1:0] sb[$];
    logic [W+1:0] exp;

    prescaled_counter #(
        .WIDTH    (W),
        .PRESCALE (P),
        .MODULO   (M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
`ifdef CNT_UPDOWN_EN
        .up       (up),
`endif
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the reference, queue its expectation.
    task automatic cycle(input logic r, input logic e, input logic l,
                         input logic [W-1:0] v, input logic u);
        logic s, mu;
        rst = r; en = e; load = l; load_val = v; up = u;
`ifdef CNT_UPDOWN_EN
        mu = u;
`else
        mu = 1'b1;
`endif
        if (r) begin
            m_ps = 0; m_count = 0; m_tick = 0; m_tc = 0;
        end else begin
            s = e && (m_ps == P - 1);
            if (l) begin
                m_count = (int'(v) >= M) ? M - 1 : int'(v);
                m_ps = 0; m_tick = 0; m_tc = 0;
            end else begin
                if (e) m_ps = (m_ps == P - 1) ? 0 : m_ps + 1;
                m_tick = s;
                m_tc   = 0;
                if (s) begin
                    if (mu) begin
                        if (m_count == M - 1) begin m_count = 0; m_tc = 1; end
                        else m_count = m_count + 1;
                    end else begin
                        if (m_count == 0) begin m_count = M - 1; m_tc = 1; end
                        else m_count = m_count - 1;
                    end
                end
            end
        end
        sb.push_back({W'(m_count), m_tick, m_tc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 4'd5, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp) begin
                failures++; $display("FAIL reset_sb i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
            checks++;
            if ({count, tick, tc} !== 6'b0000_0_0) begin
                failures++; $display("FAIL reset_state i=%0d got=%h exp=00", i, {count, tick, tc});
            end
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp) begin
                failures++; $display("FAIL reset_sb2 i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
        checks++;
        if (count !== 4'd1 || tick !== 1'b1) begin
            failures++; $display("FAIL reset_first_tick count=%0d tick=%b exp count=1 tick=1", count, tick);
        end
    endtask

    task automatic test_wrap();
        int n_tick, n_tc, tc_at;
        n_tick = 0; n_tc = 0; tc_at = -1;
        cycle(1, 0, 0, 4'd0, 1);
        void'(sb.pop_front());
        for (int i = 1; i <= 40; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp) begin
                failures++; $display("FAIL wrap_sb i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
            if (tick) n_tick++;
            if (tc) begin n_tc++; tc_at = i; end
            if (i % 4 == 0) begin
                checks++;
                if (count !== W'((i / 4) % 10) || tick !== 1'b1) begin
                    failures++; $display("FAIL wrap_step i=%0d count=%0d tick=%b exp count=%0d tick=1",
                                         i, count, tick, (i / 4) % 10);
                end
            end
        end
        checks++;
        if (n_tick != 10 || n_tc != 1 || tc_at != 40 || count !== 4'd0) begin
            failures++; $display("FAIL wrap_totals ticks=%0d tcs=%0d tc_at=%0d count=%0d exp 10/1/40/0",
                                 n_tick, n_tc, tc_at, count);
        end
    endtask

    task automatic test_enable_gap();
        cycle(1, 0, 0, 4'd0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            cycle(0, (i < 2), 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp || count !== 4'd0 || tick !== 1'b0) begin
                failures++; $display("FAIL gap_hold i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
        for (int i = 1; i <= 2; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp || tick !== (i == 2)) begin
                failures++; $display("FAIL gap_resume i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
    endtask

    task automatic test_load();
        cycle(1, 0, 0, 4'd0, 1);
        void'(sb.pop_front());
        cycle(0, 1, 0, 4'd0, 1);
        void'(sb.pop_front());
        cycle(0, 1, 1, 4'd7, 1);
        exp = sb.pop_front(); checks++;
        if ({count, tick, tc} !== exp || count !== 4'd7 || tick !== 1'b0) begin
            failures++; $display("FAIL load_mid got=%h exp=%h", {count, tick, tc}, exp);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp || count !== ((i == 4) ? 4'd8 : 4'd7)) begin
                failures++; $display("FAIL load_next i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
        cycle(0, 0, 1, 4'd12, 1);
        exp = sb.pop_front(); checks++;
        if ({count, tick, tc} !== exp || count !== 4'd9) begin
            failures++; $display("FAIL load_clamp got=%h exp=%h", {count, tick, tc}, exp);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            void'(sb.pop_front());
        end
        // Prescaler is at its terminal value: this load collides with a step.
        cycle(0, 1, 1, 4'd2, 1);
        exp = sb.pop_front(); checks++;
        if ({count, tick, tc} !== exp || count !== 4'd2 || tick !== 1'b0 || tc !== 1'b0) begin
            failures++; $display("FAIL load_on_step got=%h exp=%h", {count, tick, tc}, exp);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp || tick !== (i == 4)) begin
                failures++; $display("FAIL load_on_step_next i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
    endtask

`ifdef CNT_UPDOWN_EN
    task automatic test_down();
        cycle(1, 0, 0, 4'd0, 0);
        void'(sb.pop_front());
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0, 4'd0, 0);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp) begin
                failures++; $display("FAIL down_sb i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
            if (i == 4 || i == 8) begin
                checks++;
                if (count !== ((i == 4) ? 4'd9 : 4'd8) || tc !== (i == 4)) begin
                    failures++; $display("FAIL down_step i=%0d count=%0d tc=%b", i, count, tc);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        cycle(1, 0, 0, 4'd0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            void'(sb.pop_front());
        end
        checks++;
        if (count !== 4'd5) begin
            failures++; $display("FAIL rstmid_pre count=%0d exp=5", count);
        end
        cycle(1, 1, 1, 4'd3, 1);
        exp = sb.pop_front(); checks++;
        if ({count, tick, tc} !== exp || count !== 4'd0) begin
            failures++; $display("FAIL rstmid_over_load got=%h exp=%h", {count, tick, tc}, exp);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 0, 4'd0, 1);
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp || tick !== (i == 4)) begin
                failures++; $display("FAIL rstmid_next i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1));
            exp = sb.pop_front(); checks++;
            if ({count, tick, tc} !== exp) begin
                failures++; $display("FAIL random_sb i=%0d got=%h exp=%h", i, {count, tick, tc}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
        m_ps = 0; m_count = 0; m_tick = 0; m_tc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_enable_gap();
        test_load();
`ifdef CNT_UPDOWN_EN
        test_down();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
